// File: rtl/q_table_ctrl.sv
// -----------------------------------------------------------------------------
// q_table_ctrl
//
// Q-table storage and sequencing controller for the tic-tac-toe Q-learning
// accelerator. Accepts one transition (state, action, next_state, reward) per
// handshake, reads the nine action Q-values of next_state from a nine-bank
// table, presents them with the action and reward to the downstream update
// datapath for UPD_LAT+1 cycles, captures the returned Q_new and writes it
// back at (state, action). A zero-fill sweep runs after every reset.
//
// Ports:
//   clock, reset_n        rising-edge clock, synchronous active-low reset
//   in_valid / in_ready   transition handshake (in_ready high only in IDLE)
//   in_state              write-back address
//   in_next_state         address read for the nine Q-values
//   in_action             action 0..8 selects bank 1..9 (>8 flags err)
//   in_reward             reward, forwarded unchanged
//   q_out1..q_out9        Q-values of next_state, held through HOLD
//   q_action, q_reward    latched action / reward for the datapath
//   q_new_in              updated Q returned by the datapath
//   done                  one-cycle pulse when a transition completes
//   done_q                value written (or that would have been written)
//   err                   with done: action was out of range, nothing written
//   busy                  high in every state except IDLE
// -----------------------------------------------------------------------------
module q_table_ctrl #(
  parameter int ADDR_W  = 6,
  parameter int UPD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_state,
  input  logic [ADDR_W-1:0] in_next_state,
  input  logic [3:0]        in_action,
  input  logic [7:0]        in_reward,
  output logic [15:0]       q_out1,
  output logic [15:0]       q_out2,
  output logic [15:0]       q_out3,
  output logic [15:0]       q_out4,
  output logic [15:0]       q_out5,
  output logic [15:0]       q_out6,
  output logic [15:0]       q_out7,
  output logic [15:0]       q_out8,
  output logic [15:0]       q_out9,
  output logic [3:0]        q_action,
  output logic [7:0]        q_reward,
  input  logic [15:0]       q_new_in,
  output logic              done,
  output logic [15:0]       done_q,
  output logic              err,
  output logic              busy
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NBANKS = 9;
  // Down-counter only needs to hold UPD_LAT; keep at least one bit.
  localparam int CNT_W  = (UPD_LAT < 1) ? 1 : $clog2(UPD_LAT + 1);

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_READ  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Controller state
  // ---------------------------------------------------------------------------
  state_t            state_q,     state_d;
  logic [ADDR_W-1:0] clr_addr_q,  clr_addr_d;
  logic [ADDR_W-1:0] st_addr_q,   st_addr_d;
  logic [ADDR_W-1:0] ns_addr_q,   ns_addr_d;
  logic [3:0]        action_q,    action_d;
  logic [7:0]        reward_q,    reward_d;
  logic [CNT_W-1:0]  hold_cnt_q,  hold_cnt_d;
  logic              in_ready_q,  in_ready_d;
  logic              busy_q,      busy_d;
  logic              done_pls_q,  done_pls_d;
  logic              err_q,       err_d;
  logic [15:0]       done_val_q,  done_val_d;

  // Table port controls
  logic [NBANKS-1:0] mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [15:0]       mem_wdata_s;
  logic              rd_en_s;
  logic [15:0]       rd_data_s [NBANKS];

  // Next-state and registered-output computation for the sequencer
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    st_addr_d  = st_addr_q;
    ns_addr_d  = ns_addr_q;
    action_d   = action_q;
    reward_d   = reward_q;
    hold_cnt_d = hold_cnt_q;
    in_ready_d = in_ready_q;
    busy_d     = busy_q;
    done_pls_d = 1'b0;
    err_d      = err_q;
    done_val_d = done_val_q;

    case (state_q)
      ST_CLEAR: begin
        if (clr_addr_q == {ADDR_W{1'b1}}) begin
          // Final address is zeroed on this edge; ready from next cycle.
          state_d    = ST_IDLE;
          clr_addr_d = {ADDR_W{1'b0}};
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
        end else begin
          clr_addr_d = clr_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end

      ST_IDLE: begin
        if (in_valid) begin
          st_addr_d  = in_state;
          ns_addr_d  = in_next_state;
          action_d   = in_action;
          reward_d   = in_reward;
          state_d    = ST_READ;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_READ: begin
        // q_out registers load on this edge and then stay put through HOLD.
        hold_cnt_d = CNT_W'(UPD_LAT);
        state_d    = ST_HOLD;
      end

      ST_HOLD: begin
        if (hold_cnt_q == {CNT_W{1'b0}}) begin
          // Last HOLD edge: datapath result is valid now.
          done_val_d = q_new_in;
          err_d      = (action_q > 4'd8);
          done_pls_d = 1'b1;
          state_d    = ST_WRITE;
        end else begin
          hold_cnt_d = hold_cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      ST_WRITE: begin
        state_d    = ST_IDLE;
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
      end

      default: begin
        state_d    = ST_CLEAR;
        clr_addr_d = {ADDR_W{1'b0}};
        in_ready_d = 1'b0;
        busy_d     = 1'b1;
      end
    endcase
  end

  // Sequencer registers with synchronous active-low reset into CLEAR
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= {ADDR_W{1'b0}};
      st_addr_q  <= {ADDR_W{1'b0}};
      ns_addr_q  <= {ADDR_W{1'b0}};
      action_q   <= 4'd0;
      reward_q   <= 8'd0;
      hold_cnt_q <= {CNT_W{1'b0}};
      in_ready_q <= 1'b0;
      busy_q     <= 1'b1;
      done_pls_q <= 1'b0;
      err_q      <= 1'b0;
      done_val_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      st_addr_q  <= st_addr_d;
      ns_addr_q  <= ns_addr_d;
      action_q   <= action_d;
      reward_q   <= reward_d;
      hold_cnt_q <= hold_cnt_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_pls_q <= done_pls_d;
      err_q      <= err_d;
      done_val_q <= done_val_d;
    end
  end

  // Table port control: zero-fill in CLEAR, single-bank write in WRITE,
  // read in READ. Writes are suppressed while reset is asserted so a reset
  // landing on a WRITE cycle aborts the update.
  always_comb begin
    mem_we_s    = {NBANKS{1'b0}};
    mem_waddr_s = clr_addr_q;
    mem_wdata_s = 16'h0000;
    rd_en_s     = 1'b0;
    if (reset_n) begin
      case (state_q)
        ST_CLEAR: begin
          mem_we_s    = {NBANKS{1'b1}};
          mem_waddr_s = clr_addr_q;
        end
        ST_READ: begin
          rd_en_s = 1'b1;
        end
        ST_WRITE: begin
          if (action_q <= 4'd8) begin
            mem_we_s = {{(NBANKS-1){1'b0}}, 1'b1} << action_q;
          end else begin
            mem_we_s = {NBANKS{1'b0}};
          end
          mem_waddr_s = st_addr_q;
          mem_wdata_s = done_val_q;
        end
        default: begin
          mem_we_s = {NBANKS{1'b0}};
        end
      endcase
    end else begin
      mem_we_s = {NBANKS{1'b0}};
    end
  end

  // Nine banks; each read register doubles as the q_out holding register so
  // the presented values only change on the READ edge.
  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic [15:0] mem [DEPTH];
    logic [15:0] rd_q;

    // Bank write port
    always_ff @(posedge clock) begin
      if (mem_we_s[b]) begin
        mem[mem_waddr_s] <= mem_wdata_s;
      end
    end

    // Bank synchronous read port / q_out register
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        rd_q <= 16'h0000;
      end else if (rd_en_s) begin
        rd_q <= mem[ns_addr_q];
      end else begin
        rd_q <= rd_q;
      end
    end

    assign rd_data_s[b] = rd_q;
  end

  assign q_out1   = rd_data_s[0];
  assign q_out2   = rd_data_s[1];
  assign q_out3   = rd_data_s[2];
  assign q_out4   = rd_data_s[3];
  assign q_out5   = rd_data_s[4];
  assign q_out6   = rd_data_s[5];
  assign q_out7   = rd_data_s[6];
  assign q_out8   = rd_data_s[7];
  assign q_out9   = rd_data_s[8];
  assign q_action = action_q;
  assign q_reward = reward_q;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_pls_q;
  assign done_q   = done_val_q;
  assign err      = err_q;

endmodule

// File: tb/tb_q_table_ctrl.sv
// Self-checking bench for q_table_ctrl. dut1: ADDR_W=6, UPD_LAT=1 (directed +
// random transitions against an array model). dut3: ADDR_W=4, UPD_LAT=3
// (back-to-back requests with in_valid held high).
module tb_q_table_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  // dut1 signals
  logic        in_valid, in_ready, done, err, busy;
  logic [5:0]  in_state, in_next_state;
  logic [3:0]  in_action, q_action;
  logic [7:0]  in_reward, q_reward;
  logic [15:0] q_new_in, done_q;
  logic [15:0] q_out1, q_out2, q_out3, q_out4, q_out5, q_out6, q_out7, q_out8, q_out9;
  wire  [15:0] qo [9];
  assign qo[0] = q_out1; assign qo[1] = q_out2; assign qo[2] = q_out3;
  assign qo[3] = q_out4; assign qo[4] = q_out5; assign qo[5] = q_out6;
  assign qo[6] = q_out7; assign qo[7] = q_out8; assign qo[8] = q_out9;

  // dut3 signals
  logic        in_valid3, in_ready3, done3, err3, busy3;
  logic [3:0]  in_state3, in_next_state3;
  logic [3:0]  in_action3, q_action3;
  logic [7:0]  in_reward3, q_reward3;
  logic [15:0] q_new_in3, done_q3;
  logic [15:0] r1, r2, r3, r4, r5, r6, r7, r8, r9;
  wire  [15:0] qo3 [9];
  assign qo3[0] = r1; assign qo3[1] = r2; assign qo3[2] = r3;
  assign qo3[3] = r4; assign qo3[4] = r5; assign qo3[5] = r6;
  assign qo3[6] = r7; assign qo3[7] = r8; assign qo3[8] = r9;

  q_table_ctrl #(.ADDR_W(6), .UPD_LAT(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_next_state(in_next_state), .in_action(in_action),
    .in_reward(in_reward), .q_out1(q_out1), .q_out2(q_out2), .q_out3(q_out3),
    .q_out4(q_out4), .q_out5(q_out5), .q_out6(q_out6), .q_out7(q_out7),
    .q_out8(q_out8), .q_out9(q_out9), .q_action(q_action), .q_reward(q_reward),
    .q_new_in(q_new_in), .done(done), .done_q(done_q), .err(err), .busy(busy)
  );

  q_table_ctrl #(.ADDR_W(4), .UPD_LAT(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_state(in_state3), .in_next_state(in_next_state3), .in_action(in_action3),
    .in_reward(in_reward3), .q_out1(r1), .q_out2(r2), .q_out3(r3),
    .q_out4(r4), .q_out5(r5), .q_out6(r6), .q_out7(r7),
    .q_out8(r8), .q_out9(r9), .q_action(q_action3), .q_reward(q_reward3),
    .q_new_in(q_new_in3), .done(done3), .done_q(done_q3), .err(err3), .busy(busy3)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the table contents as a plain 2-D array.
  logic [15:0] model [9][64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int b = 0; b < 9; b++)
      for (int a = 0; a < 64; a++) model[b][a] = 16'h0000;
  endtask

  // Wait (bounded) for in_ready while sampling on negedges.
  task automatic wait_ready(input int limit, output int cycles);
    cycles = 0;
    while (in_ready !== 1'b1 && cycles < limit) begin
      cycles++;
      @(negedge clock);
    end
  endtask

  // One full transaction on dut1; called at a negedge, returns at the IDLE
  // negedge after completion.
  task automatic run_txn(input logic [5:0] st, input logic [5:0] ns,
                         input logic [3:0] act, input logic [7:0] rw,
                         input logic [15:0] qn);
    logic [15:0] exp_q [9];
    int cyc;
    wait_ready(300, cyc);
    chk("ready_before", {31'd0, in_ready}, 32'd1);
    for (int b = 0; b < 9; b++) exp_q[b] = model[b][ns];
    in_valid = 1'b1; in_state = st; in_next_state = ns;
    in_action = act; in_reward = rw; q_new_in = qn;
    @(negedge clock);                       // READ
    in_valid = 1'b0;
    chk("read_ready_busy", {30'd0, in_ready, busy}, 32'd1);
    for (int h = 0; h < 2; h++) begin       // HOLD x2
      @(negedge clock);
      for (int b = 0; b < 9; b++)
        chk($sformatf("hold%0d_q_out%0d", h, b + 1), {16'd0, qo[b]}, {16'd0, exp_q[b]});
      chk("hold_ctl", {19'd0, done, q_action, q_reward}, {19'd0, 1'b0, act, rw});
    end
    @(negedge clock);                       // WRITE
    chk("write_done", {14'd0, done, err, done_q}, {14'd0, 1'b1, (act > 4'd8), qn});
    @(negedge clock);                       // IDLE
    chk("idle_after", {29'd0, in_ready, busy, done}, 32'd4);
    chk("done_q_held", {16'd0, done_q}, {16'd0, qn});
    if (act <= 4'd8) model[act][st] = qn;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [15:0] exp_prev;
    reset_n = 1'b0;
    in_valid = 1'b0; in_state = 6'd0; in_next_state = 6'd0;
    in_action = 4'd0; in_reward = 8'd0; q_new_in = 16'h0;
    in_valid3 = 1'b0; in_state3 = 4'd0; in_next_state3 = 4'd0;
    in_action3 = 4'd0; in_reward3 = 8'd0; q_new_in3 = 16'h0;
    model_clear();

    // Reset values
    repeat (3) @(negedge clock);
    chk("rst_ctl", {28'd0, in_ready, busy, done, err}, 32'h4);
    chk("rst_done_q", {16'd0, done_q}, 32'd0);
    chk("rst_act_rw", {20'd0, q_action, q_reward}, 32'd0);
    for (int b = 0; b < 9; b++) chk($sformatf("rst_q_out%0d", b + 1), {16'd0, qo[b]}, 32'd0);

    // Clear sweep length
    reset_n = 1'b1;
    wait_ready(200, cyc);
    chk("clear_cycles", cyc, 32'd64);

    // Directed transitions
    run_txn(6'd5, 6'd5, 4'd9, 8'h01, 16'h5555);     // first read after clear: all zero
    run_txn(6'd3, 6'd7, 4'd4, 8'h10, 16'h1234);
    run_txn(6'd1, 6'd3, 4'd8, 8'h20, 16'h0042);     // q_out5 = 0x1234
    run_txn(6'd9, 6'd2, 4'd0, 8'h30, 16'h0100);     // preload
    run_txn(6'd9, 6'd9, 4'd0, 8'h40, 16'h0200);     // sees pre-update 0x0100
    run_txn(6'd0, 6'd9, 4'd1, 8'h50, 16'h0007);     // reread: 0x0200
    run_txn(6'd9, 6'd0, 4'd12, 8'h60, 16'hBEEF);    // err, no write
    run_txn(6'd2, 6'd9, 4'd2, 8'h70, 16'h0003);     // bank state 9 unchanged
    run_txn(6'd63, 6'd62, 4'd8, 8'hFF, 16'hFFFF);   // top address, last bank
    run_txn(6'd0, 6'd63, 4'd15, 8'h00, 16'h0000);

    // Random transitions over a small address range to get reuse
    for (int k = 0; k < 30; k++) begin
      run_txn(6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)),
              4'($urandom_range(0, 10)), 8'($urandom), 16'($urandom));
    end

    // Reset on the last HOLD cycle
    in_valid = 1'b1; in_state = 6'd5; in_next_state = 6'd5;
    in_action = 4'd2; in_reward = 8'h11; q_new_in = 16'h7777;
    @(negedge clock); in_valid = 1'b0;   // READ
    @(negedge clock);                    // HOLD 1
    @(negedge clock);                    // HOLD 2 (last)
    reset_n = 1'b0;
    @(negedge clock);
    chk("abort_no_done", {30'd0, done, in_ready}, 32'd0);
    chk("abort_done_q", {16'd0, done_q}, 32'd0);
    for (int b = 0; b < 9; b++) chk($sformatf("abort_q_out%0d", b + 1), {16'd0, qo[b]}, 32'd0);
    @(negedge clock);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b1;
    wait_ready(200, cyc);
    chk("reclear_cycles", cyc, 32'd64);
    model_clear();
    run_txn(6'd0, 6'd5, 4'd9, 8'h00, 16'h0001);
    run_txn(6'd0, 6'd3, 4'd9, 8'h00, 16'h0002);
    run_txn(6'd0, 6'd9, 4'd9, 8'h00, 16'h0003);

    // dut3: UPD_LAT=3, in_valid held high, st == ns, action 0
    cyc = 0;
    while (in_ready3 !== 1'b1 && cyc < 100) begin cyc++; @(negedge clock); end
    in_valid3 = 1'b1; in_state3 = 4'd2; in_next_state3 = 4'd2;
    in_action3 = 4'd0; in_reward3 = 8'h5A;
    exp_prev = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      chk("l3_idle_ready", {31'd0, in_ready3}, 32'd1);
      q_new_in3 = 16'h1000 + 16'(k);
      @(negedge clock);                          // READ
      chk("l3_read_ready", {30'd0, in_ready3, busy3}, 32'd1);
      for (int h = 0; h < 4; h++) begin          // HOLD x4
        @(negedge clock);
        chk("l3_hold_q_out1", {16'd0, qo3[0]}, {16'd0, exp_prev});
        for (int b = 1; b < 9; b++) chk("l3_hold_q_outN", {16'd0, qo3[b]}, 32'd0);
        chk("l3_hold_ctl", {18'd0, done3, in_ready3, q_action3, q_reward3}, 32'h005A);
      end
      @(negedge clock);                          // WRITE
      chk("l3_done", {15'd0, done3, err3, done_q3}, {15'd0, 1'b1, 1'b0, 16'h1000 + 16'(k)});
      exp_prev = 16'h1000 + 16'(k);
      @(negedge clock);                          // next IDLE
    end
    in_valid3 = 1'b0;
    @(negedge clock);
    chk("l3_quiet", {30'd0, done3, busy3}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/q_table_ctrl.md
# q_table_ctrl

Q-table storage and sequencing controller for the tic-tac-toe Q-learning accelerator; sits directly upstream of the Q-learning update datapath. It accepts one transition (state, action, next_state, reward) per handshake and reads the nine action Q-values of next_state from its internal banked table. It presents those values, the action and the reward to the update datapath, holds them for the datapath latency, then captures the returned Q_new and writes it into the table at (state, action). A zero-fill sweep after reset initialises the table.

## Interface
Parameters:
- ADDR_W, 6, state-address width; table depth 2^ADDR_W per bank.
- UPD_LAT, 1, register stages inside the downstream update datapath between data presentation and a valid Q_new.

Ports (one clock; reset is synchronous and active-low):
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset.
- in_valid  in  1  transition request.
- in_ready  out  1  controller can accept; high only in IDLE.
- in_state  in  ADDR_W  address written back.
- in_next_state  in  ADDR_W  address read for the nine Q-values.
- in_action  in  4  action index 0..8 selects bank 1..9.
- in_reward  in  8  reward forwarded unchanged.
- q_out1 … q_out9  out  16 each  Q-values of next_state, to datapath data inputs 1..9.
- q_action  out  4  latched action, to datapath select.
- q_reward  out  8  latched reward, to datapath.
- q_new_in  in  16  updated Q from the datapath.
- done  out  1  one-cycle pulse when a transition completes.
- done_q  out  16  value written (or would have been written) for the completed transition.
- err  out  1  valid with done; 1 means in_action > 8 and no write was performed.
- busy  out  1  high in every state except IDLE.

## Operation
- Table: nine banks, 16-bit × 2^ADDR_W each, one synchronous read port and one write port per bank.
- FSM states: CLEAR, IDLE, READ, HOLD, WRITE.
- CLEAR: entered while reset_n is low; 2^ADDR_W-step address counter writes 0 to all nine banks; on the final address go to IDLE.
- IDLE: in_ready=1. When in_valid is high, latch state, next_state, action and reward, then go to READ.
- READ: issue the read of next_state to all banks, then go to HOLD.
- HOLD: q_out1..9 are driven from the read data and held stable, with q_action and q_reward, for UPD_LAT+1 cycles (down-counter). On the last HOLD edge, sample q_new_in into done_q, then go to WRITE.
- WRITE: if the latched action ≤ 8, write done_q to bank action+1 at the latched state; otherwise no write and err=1. done=1 for this cycle. Then go to IDLE.
- The datapath registers the selected Q but takes the max combinationally, so the q_out values must stay unchanged across the whole HOLD window. They change only on leaving READ.
- state == next_state: the read precedes the write, so the datapath sees the pre-update value.
- Transitions are strictly serialised; there is no read-after-write hazard between consecutive requests.
- Widths: pass-through only, no arithmetic on Q values.

## Timing
- Reset values (while reset_n low):
  - in_ready=0, busy=1, done=0, err=0.
  - done_q=0, q_out1..9=0, q_action=0, q_reward=0.
  - FSM state=CLEAR, clear address=0.
- Clear sweep: 2^ADDR_W cycles after reset_n rises; in_ready rises on the following cycle.
- Accept edge at cycle T: READ is T+1, HOLD is T+2..T+2+UPD_LAT, WRITE is T+3+UPD_LAT (done high), IDLE/in_ready high at T+4+UPD_LAT.
- UPD_LAT=1 gives 5 cycles per transition.
- q_new_in is sampled at the end of cycle T+2+UPD_LAT.
- done_q, err and q_out* hold their values until the next transition overwrites them.
- Reset asserted mid-transition: the transition is aborted with no write and no done pulse, and a full CLEAR follows.
- in_valid while not IDLE: ignored; the requester must hold the request until in_ready.

## Test plan
- Reset release, ADDR_W=6: in_ready stays 0 for 64 cycles then rises. A first transition with next_state=5 shows q_out1..9 = 0.
- Transition state=3, action=4, next_state=7, q_new_in forced to 0x1234 → done at T+4. A following transition with next_state=3 shows q_out5=0x1234 and the other eight q_out = 0.
- state=next_state=9, action=0, preloaded Q=0x0100, q_new_in=0x0200 → during HOLD q_out1=0x0100; after done, a reread of 9 gives q_out1=0x0200.
- Action 12 with q_new_in=0xBEEF → done=1, err=1, done_q=0xBEEF; a reread shows all banks at the state unchanged.
- reset_n pulled low during HOLD → no done pulse and no write; the table reads all zero after the new CLEAR.
- UPD_LAT=3 with in_valid held high continuously → q_out stable for 4 cycles, done every 7 cycles, and in_ready high exactly one cycle per transaction.
